// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// ---------------
// Single-clock elastic buffer with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow / underflow error flags.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through: data_out shows the
//                                   head word combinationally while !empty and
//                                   rd pops it.
//                      undefined -> registered read: data_out is loaded with the
//                                   head word on the edge that accepts rd.
//
// Parameters:
//   width      data word width (>= 1)
//   depth      number of entries (power of two, >= 2)
//   af_thresh  almost_full  when count >= af_thresh (1..depth)
//   ae_thresh  almost_empty when count <= ae_thresh (0..depth-1)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   wr, data_in   write request and data
//   rd, data_out  read request and data
//   full, empty, almost_full, almost_empty   status decoded from count
//   count         occupancy 0..depth
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
//   clr_err       clears both sticky flags (a new error in the same cycle wins)
module sync_fifo_flags #(
  parameter int unsigned width     = 8,
  parameter int unsigned depth     = 16,
  parameter int unsigned af_thresh = 14,
  parameter int unsigned ae_thresh = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [width-1:0]        data_in,
  input  logic                    rd,
  output logic [width-1:0]        data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(depth):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(depth);
  localparam logic [PW-1:0] AF_C    = PW'(af_thresh);
  localparam logic [PW-1:0] AE_C    = PW'(ae_thresh);

  // Elaboration-time guard against illegal configurations.
  if (width < 1) begin : g_bad_width
    $error("sync_fifo_flags: width must be >= 1");
  end
  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: depth must be a power of two >= 2");
  end
  if (af_thresh < 1 || af_thresh > depth) begin : g_bad_af
    $error("sync_fifo_flags: af_thresh must be in 1..depth");
  end
  if (ae_thresh >= depth) begin : g_bad_ae
    $error("sync_fifo_flags: ae_thresh must be in 0..depth-1");
  end

  // Storage and state
  logic [width-1:0] mem_q [depth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Status decode from the registered count
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write into a full FIFO is still accepted when a read frees the head
  // slot on the same edge; the read samples the old word before the write
  // lands, because both use non-blocking updates of the same slot.
  assign rd_acc = rd && !empty;
  assign wr_acc = wr && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q && !clr_err) || (wr && !wr_acc);
    unf_d = (unf_q && !clr_err) || (rd && !rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Memory is not cleared on reset; stale words become unreachable once the
  // pointers return to zero.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_addr] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word presented combinationally; meaningless while empty.
  assign data_out = mem_q[rd_addr];
`else
  logic [width-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem_q[rd_addr];
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int passed = 0;
  int total  = 0;

  sync_fifo_flags #(
    .width    (8),
    .depth    (16),
    .af_thresh(14),
    .ae_thresh(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .data_in     (data_in),
    .rd          (rd),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr      = 1'b1;
    data_in = d;
    step();
    wr      = 1'b0;
  endtask

  // Pops one word and checks it: after the edge for a registered read, before
  // the edge for first-word-fall-through.
  task automatic pop(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("pop_data", data_out, exp);
    rd = 1'b1;
    step();
    rd = 1'b0;
`else
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("pop_data", data_out, exp);
`endif
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", data_out, 0);
`endif

    // Fill 0x01..0x10 sweeping thresholds, then drain back-to-back
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      chk("fill_count", count, i);
      chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
      chk("fill_af", almost_full, (i >= 14) ? 1 : 0);
      chk("fill_full", full, (i == 16) ? 1 : 0);
    end
    for (int i = 1; i <= 16; i++) begin
      pop(8'(i));
      chk("drain_count", count, 16 - i);
      chk("drain_ae", almost_empty, ((16 - i) <= 2) ? 1 : 0);
      chk("drain_af", almost_full, ((16 - i) >= 14) ? 1 : 0);
    end
    chk("drain_empty", empty, 1);

    // Simultaneous read/write while full
    for (int i = 1; i <= 16; i++) push(8'(i));
    for (int k = 0; k < 4; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("rw_full_data", data_out, 1 + k);
`endif
      wr = 1'b1; rd = 1'b1; data_in = 8'(8'hA0 + k);
      step();
      wr = 1'b0; rd = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      chk("rw_full_data", data_out, 1 + k);
`endif
      chk("rw_full_count", count, 16);
      chk("rw_full_full", full, 1);
    end
    chk("rw_full_ovf", overflow, 0);
    for (int i = 5; i <= 16; i++) pop(8'(i));
    for (int k = 0; k < 4; k++) pop(8'(8'hA0 + k));
    chk("rw_full_end_count", count, 0);

    // Simultaneous read/write while empty
    wr = 1'b1; rd = 1'b1; data_in = 8'h55;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("rw_empty_unf", underflow, 1);
    chk("rw_empty_count", count, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rw_empty_fwft", data_out, 8'h55);
`else
    chk("rw_empty_hold", data_out, 8'hA3);
`endif
    pop(8'h55);
    chk("rw_empty_count2", count, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("unf_clear", underflow, 0);

    // Overflow when full, clear/set priority
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'h99);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    clr_err = 1'b1; wr = 1'b1; data_in = 8'h9A;
    step();
    clr_err = 1'b0; wr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf_clear", overflow, 0);
    chk("ovf_unf_quiet", underflow, 0);
    for (int i = 0; i < 16; i++) pop(8'(8'h20 + i));

    // Reset mid-stream
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("pre_rst_unf", underflow, 1);
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    chk("pre_rst_count", count, 5);
    rst = 1'b1; wr = 1'b1; data_in = 8'h36;
    step();
    rst = 1'b0; wr = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ae", almost_empty, 1);
    chk("mid_rst_af", almost_full, 0);
    chk("mid_rst_unf", underflow, 0);
    chk("mid_rst_ovf", overflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_rst_dout", data_out, 0);
`endif
    push(8'h41);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_fwft", data_out, 8'h41);
`endif
    push(8'h42);
    chk("post_rst_count", count, 2);
    pop(8'h41);
    pop(8'h42);
    chk("post_rst_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
